mem_ctrl_arbiter: RTL and testbench
===================================

# mem_ctrl_arbiter

Shares the single main-memory port between the icache (read-only) and the dcache (reads and write-through stores). Each transaction is latched on grant, issued to memory, and its response is routed back to the owning cache. Only one transaction is outstanding at a time. The icache has priority, and a streak counter bounds how long the dcache can be starved. Flushed transactions still complete at memory, but their responses are dropped.

## Interface
Parameters:
- VERBOSE, 0, nonzero enables $display trace of grants and responses
- DCACHE_STARVE_LIMIT, 4, consecutive icache grants allowed while dcache waits (≥1)

Ports:
- clk  in  1  clock
- rst_aL  in  1  asynchronous, active-low reset
- flush  in  1  drop response of in-flight transaction; block grants this cycle
- icache_req_valid  in  1  icache read request
- icache_req_block_addr  in  main_mem_block_addr_t  block to read
- icache_req_ready  out  1  icache request accepted this cycle
- dcache_req_valid  in  1  dcache request
- dcache_req_type  in  req_type_t  0 read, 1 write
- dcache_req_block_addr  in  main_mem_block_addr_t  block address
- dcache_req_block_data  in  block_data_t  write data
- dcache_req_width  in  req_width_t  store width
- dcache_req_addr  in  addr_t  store byte address
- dcache_req_writethrough  in  1  write-through flag
- dcache_req_ready  out  1  dcache request accepted this cycle
- mem_req_valid  out  1  request to main memory
- mem_req_type, mem_req_block_addr, mem_req_block_data, mem_req_width, mem_req_addr, mem_req_writethrough  out  (as dcache fields)  latched request
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  memory response (reads and write acks)
- mem_resp_block_data  in  block_data_t  read data
- icache_resp_valid / dcache_resp_valid  out  1  response to owner
- icache_resp_block_data / dcache_resp_block_data  out  block_data_t  combinational copy of mem_resp_block_data

## Operation
- State machine:
  - IDLE: wait for a request and grant one.
  - REQ: hold mem_req_valid until mem_req_ready.
  - WAIT: await mem_resp_valid.
- Additional registers: owner (ICACHE/DCACHE), drop flag, latched request fields, streak counter (width $clog2(DCACHE_STARVE_LIMIT+1)).
- Grant (IDLE only, ~flush):
  - If dcache_req_valid and (streak == DCACHE_STARVE_LIMIT or ~icache_req_valid), grant the dcache.
  - Otherwise, if icache_req_valid, grant the icache.
  - At most one ready is high per cycle. The handshake completes when valid & ready.
- Icache grant:
  - Latch type=read, width=WORD, addr={block_addr, offset 0}, writethrough=0, data=0.
  - streak++ if dcache_req_valid; otherwise streak=0.
- Dcache grant: latch all dcache fields and set streak=0.
- The grant moves the state to REQ with drop=0.
- REQ: mem_req_valid=1 with fields stable. When mem_req_ready is high, go to WAIT.
- WAIT: on mem_resp_valid, pulse the owner's resp_valid for that cycle unless drop=1, then go to IDLE.
- flush:
  - In REQ or WAIT, set drop=1 (sticky until IDLE). The memory request is still issued and its response is consumed silently.
  - In IDLE, both ready signals are forced low.
- mem_resp_valid in IDLE or REQ is ignored.
- The resp_valid of the non-owner is always 0.

## Timing
- Reset: state=IDLE, owner=ICACHE, drop=0, streak=0, latched fields 0. All valid and ready outputs are 0.
- Grant in cycle T. mem_req_valid is high from T+1.
- If mem_req_ready is high at T+1, WAIT starts at T+2. Earliest response delivery is T+2, combinational with mem_resp_valid.
- Response delivered in cycle R puts the state in IDLE at R+1. The next grant is possible at R+1, so the minimum turnaround is 1 cycle.
- Ready signals depend combinationally on state, flush, streak and the request valids only. They never depend on mem_*.
- Reset asserted mid-transaction aborts immediately to the reset state. Memory-side recovery is the memory model's responsibility.
- Flush and mem_resp_valid in the same WAIT cycle: the response is suppressed and the state goes to IDLE.

## Test plan
- Lone icache read of block 0x10, mem_req_ready=1, response 3 cycles later with data 0xA5.. -> icache_resp_valid one cycle with 0xA5.., dcache_resp_valid=0, 1 outstanding.
- Dcache write at addr 0x104, width HALFWORD, writethrough=1, mem_req_ready held 0 for 4 cycles -> mem_req_* stable for all 5 cycles, then the ack pulses dcache_resp_valid.
- Both requesting continuously with DCACHE_STARVE_LIMIT=4 -> grant order I,I,I,I,D,I,I,I,I,D.
- Simultaneous valids on a fresh reset -> icache granted. Dcache granted on the next IDLE if icache is idle.
- flush asserted in WAIT of an icache read -> memory response consumed, icache_resp_valid stays 0, next grant is accepted the cycle after.
- rst_aL low during REQ -> mem_req_valid 0 immediately, streak 0, then a clean transaction after release.

Source files
------------

// File: rtl/mem_ctrl_arbiter.sv
// Arbitrates the single main-memory port between icache reads and dcache reads/stores.
// One transaction in flight; icache has priority, bounded by a dcache starvation streak.
module mem_ctrl_arbiter #(
  parameter int VERBOSE             = 0,
  parameter int DCACHE_STARVE_LIMIT = 4,
  parameter int ADDR_W              = 32,
  parameter int BLOCK_OFFSET_W      = 4,
  parameter int BLOCK_DATA_W        = 128,
  parameter int REQ_WIDTH_W         = 2,
  parameter int WIDTH_WORD          = 2
) (
  input  logic                             clk,
  input  logic                             rst_aL,
  input  logic                             flush,

  input  logic                             icache_req_valid,
  input  logic [ADDR_W-BLOCK_OFFSET_W-1:0] icache_req_block_addr,
  output logic                             icache_req_ready,

  input  logic                             dcache_req_valid,
  input  logic                             dcache_req_type,
  input  logic [ADDR_W-BLOCK_OFFSET_W-1:0] dcache_req_block_addr,
  input  logic [BLOCK_DATA_W-1:0]          dcache_req_block_data,
  input  logic [REQ_WIDTH_W-1:0]           dcache_req_width,
  input  logic [ADDR_W-1:0]                dcache_req_addr,
  input  logic                             dcache_req_writethrough,
  output logic                             dcache_req_ready,

  output logic                             mem_req_valid,
  output logic                             mem_req_type,
  output logic [ADDR_W-BLOCK_OFFSET_W-1:0] mem_req_block_addr,
  output logic [BLOCK_DATA_W-1:0]          mem_req_block_data,
  output logic [REQ_WIDTH_W-1:0]           mem_req_width,
  output logic [ADDR_W-1:0]                mem_req_addr,
  output logic                             mem_req_writethrough,
  input  logic                             mem_req_ready,

  input  logic                             mem_resp_valid,
  input  logic [BLOCK_DATA_W-1:0]          mem_resp_block_data,

  output logic                             icache_resp_valid,
  output logic [BLOCK_DATA_W-1:0]          icache_resp_block_data,
  output logic                             dcache_resp_valid,
  output logic [BLOCK_DATA_W-1:0]          dcache_resp_block_data
);

  localparam int BLOCK_ADDR_W = ADDR_W - BLOCK_OFFSET_W;
  localparam int STREAK_W     = $clog2(DCACHE_STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0]    STREAK_LIMIT = STREAK_W'(DCACHE_STARVE_LIMIT);
  localparam logic [REQ_WIDTH_W-1:0] WORD_CODE    = REQ_WIDTH_W'(WIDTH_WORD);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  typedef enum logic {
    OWNER_ICACHE,
    OWNER_DCACHE
  } owner_e;

  state_e                    state_q, state_d;
  owner_e                    owner_q, owner_d;
  logic                      drop_q, drop_d;
  logic [STREAK_W-1:0]       streak_q, streak_d;

  logic                      type_q, type_d;
  logic [BLOCK_ADDR_W-1:0]   blk_q, blk_d;
  logic [BLOCK_DATA_W-1:0]   data_q, data_d;
  logic [REQ_WIDTH_W-1:0]    width_q, width_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      wt_q, wt_d;

  logic                      gnt_icache;
  logic                      gnt_dcache;
  logic                      resp_show;

  // Trace output is a simulation-only concern; VERBOSE is retained in the parameter list.
  logic unused_verbose;
  assign unused_verbose = (VERBOSE != 0);

  // Grants are also held off while reset is asserted so readies read 0 in reset.
  always_comb begin
    gnt_icache = 1'b0;
    gnt_dcache = 1'b0;
    if (rst_aL && state_q == IDLE && !flush) begin
      if (dcache_req_valid && (streak_q == STREAK_LIMIT || !icache_req_valid)) begin
        gnt_dcache = 1'b1;
      end else if (icache_req_valid) begin
        gnt_icache = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (gnt_icache || gnt_dcache) state_d = REQ;
      REQ:  if (mem_req_ready)            state_d = WAIT;
      WAIT: if (mem_resp_valid)           state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  always_comb begin
    icache_req_ready  = gnt_icache;
    dcache_req_ready  = gnt_dcache;
    mem_req_valid     = (state_q == REQ);
    resp_show         = (state_q == WAIT) && mem_resp_valid && !drop_q && !flush;
    icache_resp_valid = resp_show && (owner_q == OWNER_ICACHE);
    dcache_resp_valid = resp_show && (owner_q == OWNER_DCACHE);
  end

  always_comb begin
    owner_d  = owner_q;
    drop_d   = drop_q;
    streak_d = streak_q;
    type_d   = type_q;
    blk_d    = blk_q;
    data_d   = data_q;
    width_d  = width_q;
    addr_d   = addr_q;
    wt_d     = wt_q;
    if (gnt_icache) begin
      owner_d  = OWNER_ICACHE;
      drop_d   = 1'b0;
      type_d   = 1'b0;
      blk_d    = icache_req_block_addr;
      data_d   = '0;
      width_d  = WORD_CODE;
      addr_d   = {icache_req_block_addr, {BLOCK_OFFSET_W{1'b0}}};
      wt_d     = 1'b0;
      streak_d = dcache_req_valid ? streak_q + STREAK_W'(1) : '0;
    end else if (gnt_dcache) begin
      owner_d  = OWNER_DCACHE;
      drop_d   = 1'b0;
      type_d   = dcache_req_type;
      blk_d    = dcache_req_block_addr;
      data_d   = dcache_req_block_data;
      width_d  = dcache_req_width;
      addr_d   = dcache_req_addr;
      wt_d     = dcache_req_writethrough;
      streak_d = '0;
    end else if (flush && state_q != IDLE) begin
      drop_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      owner_q  <= OWNER_ICACHE;
      drop_q   <= 1'b0;
      streak_q <= '0;
      type_q   <= 1'b0;
      blk_q    <= '0;
      data_q   <= '0;
      width_q  <= '0;
      addr_q   <= '0;
      wt_q     <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      drop_q   <= drop_d;
      streak_q <= streak_d;
      type_q   <= type_d;
      blk_q    <= blk_d;
      data_q   <= data_d;
      width_q  <= width_d;
      addr_q   <= addr_d;
      wt_q     <= wt_d;
    end
  end

  assign mem_req_type           = type_q;
  assign mem_req_block_addr     = blk_q;
  assign mem_req_block_data     = data_q;
  assign mem_req_width          = width_q;
  assign mem_req_addr           = addr_q;
  assign mem_req_writethrough   = wt_q;

  assign icache_resp_block_data = mem_resp_block_data;
  assign dcache_resp_block_data = mem_resp_block_data;

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Scoreboard bench for mem_ctrl_arbiter: a transaction-level model predicts each cycle,
// a negedge monitor compares the DUT against the queued predictions.
module tb_mem_ctrl_arbiter;

  localparam int LIMIT = 4;
  localparam int AW    = 32;
  localparam int OFW   = 4;
  localparam int BAW   = AW - OFW;
  localparam int DW    = 128;
  localparam int WW    = 2;
  localparam logic [WW-1:0] W_HALF = 2'd1;
  localparam logic [WW-1:0] W_WORD = 2'd2;

  typedef struct packed {
    logic           typ;
    logic [BAW-1:0] blk;
    logic [DW-1:0]  data;
    logic [WW-1:0]  width;
    logic [AW-1:0]  addr;
    logic           wt;
  } mreq_t;

  typedef struct {
    bit    rdy_i;
    bit    rdy_d;
    bit    mvalid;
    bit    iresp;
    bit    dresp;
    mreq_t req;
  } cyc_t;

  typedef struct {
    bit            owner_d;
    logic [DW-1:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst_aL, flush;
  logic icache_req_valid;
  logic [BAW-1:0] icache_req_block_addr;
  logic icache_req_ready;
  logic dcache_req_valid, dcache_req_type, dcache_req_writethrough;
  logic [BAW-1:0] dcache_req_block_addr;
  logic [DW-1:0] dcache_req_block_data;
  logic [WW-1:0] dcache_req_width;
  logic [AW-1:0] dcache_req_addr;
  logic dcache_req_ready;
  logic mem_req_valid, mem_req_type, mem_req_writethrough, mem_req_ready;
  logic [BAW-1:0] mem_req_block_addr;
  logic [DW-1:0] mem_req_block_data;
  logic [WW-1:0] mem_req_width;
  logic [AW-1:0] mem_req_addr;
  logic mem_resp_valid;
  logic [DW-1:0] mem_resp_block_data;
  logic icache_resp_valid, dcache_resp_valid;
  logic [DW-1:0] icache_resp_block_data, dcache_resp_block_data;

  always #5 clk = ~clk;

  mem_ctrl_arbiter #(
    .VERBOSE(0),
    .DCACHE_STARVE_LIMIT(LIMIT),
    .ADDR_W(AW),
    .BLOCK_OFFSET_W(OFW),
    .BLOCK_DATA_W(DW),
    .REQ_WIDTH_W(WW),
    .WIDTH_WORD(2)
  ) dut (
    .clk(clk),
    .rst_aL(rst_aL),
    .flush(flush),
    .icache_req_valid(icache_req_valid),
    .icache_req_block_addr(icache_req_block_addr),
    .icache_req_ready(icache_req_ready),
    .dcache_req_valid(dcache_req_valid),
    .dcache_req_type(dcache_req_type),
    .dcache_req_block_addr(dcache_req_block_addr),
    .dcache_req_block_data(dcache_req_block_data),
    .dcache_req_width(dcache_req_width),
    .dcache_req_addr(dcache_req_addr),
    .dcache_req_writethrough(dcache_req_writethrough),
    .dcache_req_ready(dcache_req_ready),
    .mem_req_valid(mem_req_valid),
    .mem_req_type(mem_req_type),
    .mem_req_block_addr(mem_req_block_addr),
    .mem_req_block_data(mem_req_block_data),
    .mem_req_width(mem_req_width),
    .mem_req_addr(mem_req_addr),
    .mem_req_writethrough(mem_req_writethrough),
    .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_block_data(mem_resp_block_data),
    .icache_resp_valid(icache_resp_valid),
    .icache_resp_block_data(icache_resp_block_data),
    .dcache_resp_valid(dcache_resp_valid),
    .dcache_resp_block_data(dcache_resp_block_data)
  );

  cyc_t  cyc_q[$];
  resp_t resp_q[$];
  bit    grant_log[$];
  int    checks = 0;
  int    errors = 0;

  // Transaction-level model state: is a transaction outstanding, has memory taken it,
  // will its answer be thrown away, who owns it, how long dcache has waited.
  bit    m_busy, m_issued, m_drop, m_own_d;
  int    m_streak;
  mreq_t m_req;
  bit    gi, gd;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model();
    cyc_t  c;
    resp_t r;
    bit    deliver;
    gi = 0;
    gd = 0;
    c.rdy_i = 0; c.rdy_d = 0; c.mvalid = 0; c.iresp = 0; c.dresp = 0;
    c.req = '0;
    if (!rst_aL) begin
      m_busy = 0; m_issued = 0; m_drop = 0; m_own_d = 0; m_streak = 0; m_req = '0;
      resp_q.delete();
      cyc_q.push_back(c);
      return;
    end
    c.mvalid = m_busy && !m_issued;
    c.req    = m_req;
    if (!m_busy && !flush) begin
      if (dcache_req_valid && (m_streak == LIMIT || !icache_req_valid)) gd = 1;
      else if (icache_req_valid) gi = 1;
    end
    c.rdy_i = gi;
    c.rdy_d = gd;
    deliver = m_busy && m_issued && mem_resp_valid;
    if (deliver && !m_drop && !flush) begin
      c.iresp   = !m_own_d;
      c.dresp   = m_own_d;
      r.owner_d = m_own_d;
      r.data    = mem_resp_block_data;
      resp_q.push_back(r);
    end
    if (m_busy && flush) m_drop = 1;
    if (m_busy && !m_issued && mem_req_ready) m_issued = 1;
    if (deliver) m_busy = 0;
    if (gi) begin
      m_req = '{typ: 1'b0, blk: icache_req_block_addr, data: '0, width: W_WORD,
                addr: {icache_req_block_addr, 4'h0}, wt: 1'b0};
      m_own_d  = 0;
      m_streak = dcache_req_valid ? m_streak + 1 : 0;
    end
    if (gd) begin
      m_req = '{typ: dcache_req_type, blk: dcache_req_block_addr, data: dcache_req_block_data,
                width: dcache_req_width, addr: dcache_req_addr, wt: dcache_req_writethrough};
      m_own_d  = 1;
      m_streak = 0;
    end
    if (gi || gd) begin
      m_busy = 1; m_issued = 0; m_drop = 0;
    end
    cyc_q.push_back(c);
  endtask

  cyc_t  mon_c;
  resp_t mon_r;
  mreq_t mon_a;

  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mon_c = cyc_q.pop_front();
      chk1("icache_req_ready", icache_req_ready, mon_c.rdy_i);
      chk1("dcache_req_ready", dcache_req_ready, mon_c.rdy_d);
      chk1("mem_req_valid", mem_req_valid, mon_c.mvalid);
      chk1("icache_resp_valid", icache_resp_valid, mon_c.iresp);
      chk1("dcache_resp_valid", dcache_resp_valid, mon_c.dresp);
      if (mon_c.mvalid) begin
        mon_a = '{typ: mem_req_type, blk: mem_req_block_addr, data: mem_req_block_data,
                  width: mem_req_width, addr: mem_req_addr, wt: mem_req_writethrough};
        chkw("mem_req_fields", 256'(mon_a), 256'(mon_c.req));
      end
    end
    if (icache_req_valid && icache_req_ready) grant_log.push_back(1'b0);
    if (dcache_req_valid && dcache_req_ready) grant_log.push_back(1'b1);
    if (icache_resp_valid || dcache_resp_valid) begin
      if (resp_q.size() == 0) begin
        chk1("unexpected_resp", 1'b1, 1'b0);
      end else begin
        mon_r = resp_q.pop_front();
        chk1("resp_owner", dcache_resp_valid, mon_r.owner_d);
        chkw("resp_data", 256'(dcache_resp_valid ? dcache_resp_block_data : icache_resp_block_data),
             256'(mon_r.data));
      end
    end
  end

  task automatic tick();
    model();
    @(posedge clk);
    #1;
  endtask

  task automatic new_dreq();
    dcache_req_valid        = 1'b1;
    dcache_req_type         = 1'($urandom_range(0, 1));
    dcache_req_block_addr   = BAW'($urandom);
    dcache_req_addr         = {dcache_req_block_addr, 4'($urandom)};
    dcache_req_width        = WW'($urandom_range(0, 2));
    dcache_req_writethrough = 1'($urandom_range(0, 1));
    dcache_req_block_data   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic idle_inputs();
    icache_req_valid = 0; dcache_req_valid = 0; flush = 0;
    mem_req_ready = 0; mem_resp_valid = 0;
  endtask

  task automatic drain();
    idle_inputs();
    mem_req_ready  = 1;
    mem_resp_valid = 1;
    repeat (4) tick();
    mem_req_ready  = 0;
    mem_resp_valid = 0;
    tick();
  endtask

  initial begin
    bit exp_order[10];
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    rst_aL = 0;
    idle_inputs();
    icache_req_block_addr = '0;
    dcache_req_type = 0; dcache_req_block_addr = '0; dcache_req_block_data = '0;
    dcache_req_width = '0; dcache_req_addr = '0; dcache_req_writethrough = 0;
    mem_resp_block_data = '0;
    @(posedge clk);
    #1;
    icache_req_valid = 1;
    repeat (2) tick();
    icache_req_valid = 0;
    tick();
    rst_aL = 1;

    // Both caches requesting continuously from a fresh reset.
    grant_log.delete();
    icache_req_valid = 1; icache_req_block_addr = BAW'($urandom);
    new_dreq();
    mem_req_ready = 1; mem_resp_valid = 1;
    mem_resp_block_data = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 40; i++) begin
      tick();
      if (gi) icache_req_block_addr = BAW'($urandom);
      if (gd) new_dreq();
      mem_resp_block_data = {$urandom, $urandom, $urandom, $urandom};
    end
    drain();
    chk1("grant_count_ge_10", grant_log.size() >= 10, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i < grant_log.size()) chk1($sformatf("grant_order[%0d]", i), grant_log[i], exp_order[i]);
    end

    // Lone icache read of block 0x10, response three cycles after issue.
    icache_req_valid = 1; icache_req_block_addr = 28'h10; mem_req_ready = 1;
    tick();
    icache_req_valid = 0;
    tick();
    mem_req_ready = 0;
    repeat (2) tick();
    mem_resp_valid = 1; mem_resp_block_data = {16{8'hA5}};
    tick();
    mem_resp_valid = 0;
    tick();

    // Dcache write-through halfword store, memory stalls for four cycles.
    dcache_req_valid = 1; dcache_req_type = 1; dcache_req_block_addr = 28'h10;
    dcache_req_addr = 32'h104; dcache_req_width = W_HALF; dcache_req_writethrough = 1;
    dcache_req_block_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    dcache_req_valid = 0;
    repeat (4) tick();
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    tick();
    mem_resp_valid = 1; mem_resp_block_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    mem_resp_valid = 0;
    tick();

    // Flush while idle blocks grants; flush in WAIT swallows the response.
    flush = 1; icache_req_valid = 1; dcache_req_valid = 1;
    tick();
    flush = 0; dcache_req_valid = 0; icache_req_block_addr = BAW'($urandom);
    mem_req_ready = 1;
    tick();
    icache_req_valid = 0;
    tick();
    mem_req_ready = 0;
    tick();
    flush = 1; mem_resp_valid = 1;
    tick();
    flush = 0; mem_resp_valid = 0; icache_req_valid = 1; icache_req_block_addr = BAW'($urandom);
    tick();
    icache_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_resp_valid = 1; mem_resp_block_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    mem_resp_valid = 0; mem_req_ready = 0;
    tick();

    // Reset asserted while a request is waiting for memory.
    icache_req_valid = 1; icache_req_block_addr = BAW'($urandom);
    tick();
    icache_req_valid = 0;
    tick();
    icache_req_valid = 1; rst_aL = 0;
    tick();
    rst_aL = 1; icache_req_block_addr = BAW'($urandom); mem_req_ready = 1;
    tick();
    icache_req_valid = 0;
    tick();
    mem_resp_valid = 1; mem_resp_block_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    mem_resp_valid = 0; mem_req_ready = 0;
    tick();

    // Randomized traffic with flushes and spurious memory responses.
    for (int i = 0; i < 3000; i++) begin
      flush               = ($urandom_range(0, 99) < 4);
      mem_req_ready       = 1'($urandom_range(0, 1));
      mem_resp_valid      = ($urandom_range(0, 99) < 35);
      mem_resp_block_data = {$urandom, $urandom, $urandom, $urandom};
      if (!icache_req_valid && $urandom_range(0, 99) < 40) begin
        icache_req_valid = 1; icache_req_block_addr = BAW'($urandom);
      end
      if (!dcache_req_valid && $urandom_range(0, 99) < 40) new_dreq();
      tick();
      if (gi) icache_req_valid = 0;
      if (gd) dcache_req_valid = 0;
    end
    drain();
    @(negedge clk);
    #1;
    chk1("cyc_q_drained", cyc_q.size() == 0, 1'b1);
    chk1("resp_q_drained", resp_q.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
